// File: rtl/ramen_countdown_pkg.sv
// Shared types and constants for the ramen countdown timer.
package ramen_countdown_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_ALARM
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_t;
        bcd_t min_o;
        bcd_t sec_t;
        bcd_t sec_o;
    } time_t;

    // Active-low segment patterns, bit order gfedcba.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic time_t time_from_min(input int unsigned m);
        time_t t;
        t.min_t = 4'(m / 10);
        t.min_o = 4'(m % 10);
        t.sec_t = '0;
        t.sec_o = '0;
        return t;
    endfunction

endpackage

// File: rtl/ramen_countdown_seg7.sv
// BCD digit to active-low 7-segment pattern with decimal point and blanking.
module seg7_encode
    import ramen_countdown_pkg::*;
(
    input  bcd_t       i_digit,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    logic [6:0] w_pat;

    always_comb begin
        w_pat = SEG_BLANK;
        case (i_digit)
            4'd0: w_pat = SEG_0;
            4'd1: w_pat = SEG_1;
            4'd2: w_pat = SEG_2;
            4'd3: w_pat = SEG_3;
            4'd4: w_pat = SEG_4;
            4'd5: w_pat = SEG_5;
            4'd6: w_pat = SEG_6;
            4'd7: w_pat = SEG_7;
            4'd8: w_pat = SEG_8;
            4'd9: w_pat = SEG_9;
            default: w_pat = SEG_BLANK;
        endcase
        o_seg = i_blank ? 8'hFF : {~i_dp, w_pat};
    end

endmodule

// File: rtl/ramen_countdown.sv
// Kitchen countdown timer: MM:SS BCD time, button set-up, run/pause, blinking alarm.
module ramen_countdown
    import ramen_countdown_pkg::*;
#(
    parameter int unsigned DEFAULT_MIN = 3,
    parameter int unsigned ALARM_SECS  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_1s,
    input  logic            btn_min,
    input  logic            btn_sec,
    input  logic            btn_start,
    input  logic            btn_clr,
    output logic [3:0][7:0] hex_7seg,
    output logic            running,
    output logic            alarm
);

    localparam time_t      DEFAULT_TIME = time_from_min(DEFAULT_MIN);
    localparam logic [7:0] ALARM_LAST   = 8'(ALARM_SECS - 1);

    state_t     r_state,     w_state_nxt;
    time_t      r_time,      w_time_nxt;
    time_t      r_preset,    w_preset_nxt;
    logic [7:0] r_alarm_cnt, w_alarm_cnt_nxt;
    logic       r_blink,     w_blink_nxt;
    time_t      w_time_dec;
    logic       w_blank;

    function automatic logic [7:0] inc59(input logic [7:0] f);
        if (f == 8'h59)      return 8'h00;
        if (f[3:0] == 4'd9)  return {f[7:4] + 4'd1, 4'd0};
        return {f[7:4], f[3:0] + 4'd1};
    endfunction

    function automatic time_t dec_time(input time_t t);
        time_t d;
        d = t;
        if (t.sec_o != 4'd0) begin
            d.sec_o = t.sec_o - 4'd1;
        end else begin
            d.sec_o = 4'd9;
            if (t.sec_t != 4'd0) begin
                d.sec_t = t.sec_t - 4'd1;
            end else begin
                d.sec_t = 4'd5;
                if (t.min_o != 4'd0) begin
                    d.min_o = t.min_o - 4'd1;
                end else begin
                    d.min_o = 4'd9;
                    d.min_t = t.min_t - 4'd1;
                end
            end
        end
        return d;
    endfunction

    assign w_time_dec = dec_time(r_time);
    assign w_blank    = (r_state == S_ALARM) && r_blink;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_time      <= DEFAULT_TIME;
            r_preset    <= DEFAULT_TIME;
            r_alarm_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_time      <= w_time_nxt;
            r_preset    <= w_preset_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
            r_blink     <= w_blink_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_time_nxt      = r_time;
        w_preset_nxt    = r_preset;
        w_alarm_cnt_nxt = r_alarm_cnt;
        w_blink_nxt     = r_blink;
        running         = (r_state == S_RUN);
        alarm           = (r_state == S_ALARM);

        if (btn_clr) begin
            w_state_nxt     = S_IDLE;
            w_time_nxt      = DEFAULT_TIME;
            w_preset_nxt    = DEFAULT_TIME;
            w_alarm_cnt_nxt = '0;
            w_blink_nxt     = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A start press at 00:00 is ignored but still outranks min/sec.
                    if (btn_start) begin
                        if (r_time != '0) begin
                            w_state_nxt  = S_RUN;
                            w_preset_nxt = r_time;
                        end
                    end else if (btn_min) begin
                        {w_time_nxt.min_t, w_time_nxt.min_o} = inc59({r_time.min_t, r_time.min_o});
                    end else if (btn_sec) begin
                        {w_time_nxt.sec_t, w_time_nxt.sec_o} = inc59({r_time.sec_t, r_time.sec_o});
                    end
                end
                S_RUN: begin
                    if (btn_start) begin
                        w_state_nxt = S_PAUSE;
                    end else if (tick_1s) begin
                        w_time_nxt = w_time_dec;
                        if (w_time_dec == '0) begin
                            w_state_nxt     = S_ALARM;
                            w_alarm_cnt_nxt = '0;
                            w_blink_nxt     = 1'b0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (btn_start) w_state_nxt = S_RUN;
                end
                S_ALARM: begin
                    if (btn_start || (tick_1s && r_alarm_cnt == ALARM_LAST)) begin
                        w_state_nxt     = S_IDLE;
                        w_time_nxt      = r_preset;
                        w_alarm_cnt_nxt = '0;
                        w_blink_nxt     = 1'b0;
                    end else if (tick_1s) begin
                        w_alarm_cnt_nxt = r_alarm_cnt + 8'd1;
                        w_blink_nxt     = ~r_blink;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_seg
        seg7_encode u_seg (
            .i_digit (r_time[4*gi +: 4]),
            .i_dp    (gi == 2),
            .i_blank (w_blank),
            .o_seg   (hex_7seg[gi])
        );
    end

endmodule

// File: tb/tb_ramen_countdown.sv
// Directed self-checking bench for ramen_countdown (DEFAULT_MIN=3, ALARM_SECS=10).
module tb_ramen_countdown;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick_1s = 1'b0, btn_min = 1'b0, btn_sec = 1'b0;
    logic            btn_start = 1'b0, btn_clr = 1'b0;
    logic [3:0][7:0] hex_7seg;
    logic            running, alarm;
    int              n_tests = 0;
    int              n_fail = 0;

    ramen_countdown #(.DEFAULT_MIN(3), .ALARM_SECS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1s   (tick_1s),
        .btn_min   (btn_min),
        .btn_sec   (btn_sec),
        .btn_start (btn_start),
        .btn_clr   (btn_clr),
        .hex_7seg  (hex_7seg),
        .running   (running),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [31:0] exp_hex(input int unsigned mm, input int unsigned ss, input bit blank);
        if (blank) return 32'hFFFF_FFFF;
        return {1'b1, seg_of(mm / 10), 1'b0, seg_of(mm % 10),
                1'b1, seg_of(ss / 10), 1'b1, seg_of(ss % 10)};
    endfunction

    task automatic step(input bit t, input bit m, input bit s, input bit st, input bit c);
        tick_1s = t; btn_min = m; btn_sec = s; btn_start = st; btn_clr = c;
        @(posedge clk);
        #1;
        tick_1s = 0; btn_min = 0; btn_sec = 0; btn_start = 0; btn_clr = 0;
    endtask

    task automatic repeat_btn(input int unsigned n, input bit m, input bit s);
        for (int i = 0; i < int'(n); i++) step(0, m, s, 0, 0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (hex_7seg !== exp_hex(3, 0, 0) || running !== 1'b0 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: hex=%h run=%b alm=%b, required hex=%h run=0 alm=0",
                     hex_7seg, running, alarm, exp_hex(3, 0, 0));
        end
    endtask

    task automatic test_full_countdown;
        int unsigned rem;
        step(0, 0, 0, 1, 0);
        n_tests++;
        if (running !== 1'b1 || hex_7seg !== exp_hex(3, 0, 0)) begin
            n_fail++;
            $display("FAIL start: run=%b hex=%h, required run=1 hex=%h", running, hex_7seg, exp_hex(3, 0, 0));
        end
        for (int k = 1; k <= 180; k++) begin
            step(1, 0, 0, 0, 0);
            rem = 180 - k;
            n_tests++;
            if (k < 180) begin
                if (hex_7seg !== exp_hex(rem / 60, rem % 60, 0) || alarm !== 1'b0 || running !== 1'b1) begin
                    n_fail++;
                    $display("FAIL countdown tick %0d: hex=%h alm=%b run=%b, required hex=%h alm=0 run=1",
                             k, hex_7seg, alarm, running, exp_hex(rem / 60, rem % 60, 0));
                end
            end else if (alarm !== 1'b1 || running !== 1'b0 || hex_7seg !== exp_hex(0, 0, 0)) begin
                n_fail++;
                $display("FAIL alarm entry: alm=%b run=%b hex=%h, required alm=1 run=0 hex=%h",
                         alarm, running, hex_7seg, exp_hex(0, 0, 0));
            end
        end
        for (int j = 1; j <= 10; j++) begin
            step(1, 0, 0, 0, 0);
            n_tests++;
            if (j < 10) begin
                if (alarm !== 1'b1 || hex_7seg !== exp_hex(0, 0, (j % 2) == 1)) begin
                    n_fail++;
                    $display("FAIL alarm tick %0d: alm=%b hex=%h, required alm=1 hex=%h",
                             j, alarm, hex_7seg, exp_hex(0, 0, (j % 2) == 1));
                end
            end else if (alarm !== 1'b0 || running !== 1'b0 || hex_7seg !== exp_hex(3, 0, 0)) begin
                n_fail++;
                $display("FAIL alarm timeout: alm=%b run=%b hex=%h, required alm=0 run=0 hex=%h",
                         alarm, running, hex_7seg, exp_hex(3, 0, 0));
            end
        end
    endtask

    task automatic test_buttons;
        for (int i = 1; i <= 61; i++) begin
            step(0, 1, 0, 0, 0);
            if (i == 56 || i == 57 || i == 61) begin
                n_tests++;
                if (hex_7seg !== exp_hex((3 + i) % 60, 0, 0)) begin
                    n_fail++;
                    $display("FAIL btn_min x%0d: hex=%h, required %h", i, hex_7seg, exp_hex((3 + i) % 60, 0, 0));
                end
            end
        end
        for (int i = 1; i <= 60; i++) begin
            step(0, 0, 1, 0, 0);
            if (i == 59 || i == 60) begin
                n_tests++;
                if (hex_7seg !== exp_hex(4, i % 60, 0)) begin
                    n_fail++;
                    $display("FAIL btn_sec x%0d: hex=%h, required %h", i, hex_7seg, exp_hex(4, i % 60, 0));
                end
            end
        end
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        n_tests++;
        if (running !== 1'b1 || hex_7seg !== exp_hex(4, 0, 0)) begin
            n_fail++;
            $display("FAIL buttons in RUN: run=%b hex=%h, required run=1 hex=%h", running, hex_7seg, exp_hex(4, 0, 0));
        end
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        n_tests++;
        if (running !== 1'b0 || hex_7seg !== exp_hex(4, 0, 0)) begin
            n_fail++;
            $display("FAIL btn_min in PAUSE: run=%b hex=%h, required run=0 hex=%h", running, hex_7seg, exp_hex(4, 0, 0));
        end
        step(0, 0, 0, 0, 1);
        n_tests++;
        if (running !== 1'b0 || hex_7seg !== exp_hex(3, 0, 0)) begin
            n_fail++;
            $display("FAIL clear from PAUSE: run=%b hex=%h, required run=0 hex=%h", running, hex_7seg, exp_hex(3, 0, 0));
        end
    endtask

    task automatic test_pause_same_cycle;
        repeat_btn(57, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        n_tests++;
        if (running !== 1'b0 || alarm !== 1'b0 || hex_7seg !== exp_hex(0, 1, 0)) begin
            n_fail++;
            $display("FAIL start+tick pause: run=%b alm=%b hex=%h, required run=0 alm=0 hex=%h",
                     running, alarm, hex_7seg, exp_hex(0, 1, 0));
        end
        step(1, 0, 0, 0, 0);
        n_tests++;
        if (hex_7seg !== exp_hex(0, 1, 0) || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL tick in PAUSE: hex=%h alm=%b, required hex=%h alm=0", hex_7seg, alarm, exp_hex(0, 1, 0));
        end
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        n_tests++;
        if (alarm !== 1'b1 || hex_7seg !== exp_hex(0, 0, 0)) begin
            n_fail++;
            $display("FAIL resume to alarm: alm=%b hex=%h, required alm=1 hex=%h", alarm, hex_7seg, exp_hex(0, 0, 0));
        end
    endtask

    task automatic test_alarm_blink;
        step(1, 0, 0, 0, 0);
        n_tests++;
        if (hex_7seg !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL blink first tick: hex=%h, required ffffffff", hex_7seg);
        end
        step(1, 0, 0, 0, 0);
        n_tests++;
        if (hex_7seg !== exp_hex(0, 0, 0) || hex_7seg[2][7] !== 1'b0 || hex_7seg[3][7] !== 1'b1) begin
            n_fail++;
            $display("FAIL blink second tick/dp: hex=%h, required %h", hex_7seg, exp_hex(0, 0, 0));
        end
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        n_tests++;
        if (alarm !== 1'b0 || running !== 1'b0 || hex_7seg !== exp_hex(0, 1, 0)) begin
            n_fail++;
            $display("FAIL alarm ack: alm=%b run=%b hex=%h, required alm=0 run=0 hex=%h",
                     alarm, running, hex_7seg, exp_hex(0, 1, 0));
        end
    endtask

    task automatic test_clear;
        repeat_btn(59, 0, 1);
        step(0, 0, 0, 1, 0);
        n_tests++;
        if (running !== 1'b0 || hex_7seg !== exp_hex(0, 0, 0)) begin
            n_fail++;
            $display("FAIL start at 00:00: run=%b hex=%h, required run=0 hex=%h", running, hex_7seg, exp_hex(0, 0, 0));
        end
        step(0, 0, 0, 1, 1);
        n_tests++;
        if (running !== 1'b0 || hex_7seg !== exp_hex(3, 0, 0)) begin
            n_fail++;
            $display("FAIL clr+start priority: run=%b hex=%h, required run=0 hex=%h", running, hex_7seg, exp_hex(3, 0, 0));
        end
        step(0, 1, 0, 1, 0);
        n_tests++;
        if (running !== 1'b1 || hex_7seg !== exp_hex(3, 0, 0)) begin
            n_fail++;
            $display("FAIL start+min priority: run=%b hex=%h, required run=1 hex=%h", running, hex_7seg, exp_hex(3, 0, 0));
        end
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        n_tests++;
        if (hex_7seg !== exp_hex(4, 0, 0)) begin
            n_fail++;
            $display("FAIL min+sec priority: hex=%h, required %h", hex_7seg, exp_hex(4, 0, 0));
        end
        step(0, 0, 0, 0, 1);
        repeat_btn(57, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        n_tests++;
        if (alarm !== 1'b0 || running !== 1'b0 || hex_7seg !== exp_hex(3, 0, 0)) begin
            n_fail++;
            $display("FAIL clr in ALARM: alm=%b run=%b hex=%h, required alm=0 run=0 hex=%h",
                     alarm, running, hex_7seg, exp_hex(3, 0, 0));
        end
    endtask

    task automatic test_async_reset;
        repeat_btn(58, 1, 0);
        repeat_btn(23, 0, 1);
        step(0, 0, 0, 1, 0);
        n_tests++;
        if (running !== 1'b1 || hex_7seg !== exp_hex(1, 23, 0)) begin
            n_fail++;
            $display("FAIL run at 01:23: run=%b hex=%h, required run=1 hex=%h", running, hex_7seg, exp_hex(1, 23, 0));
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (running !== 1'b0 || alarm !== 1'b0 || hex_7seg !== exp_hex(3, 0, 0)) begin
            n_fail++;
            $display("FAIL async reset in RUN: run=%b alm=%b hex=%h, required run=0 alm=0 hex=%h",
                     running, alarm, hex_7seg, exp_hex(3, 0, 0));
        end
        #2 rst = 1'b0;
        step(1, 0, 0, 0, 0);
        n_tests++;
        if (running !== 1'b0 || hex_7seg !== exp_hex(3, 0, 0)) begin
            n_fail++;
            $display("FAIL post-reset idle: run=%b hex=%h, required run=0 hex=%h", running, hex_7seg, exp_hex(3, 0, 0));
        end
        repeat_btn(57, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (alarm !== 1'b0 || running !== 1'b0 || hex_7seg !== exp_hex(3, 0, 0)) begin
            n_fail++;
            $display("FAIL async reset in ALARM: alm=%b run=%b hex=%h, required alm=0 run=0 hex=%h",
                     alarm, running, hex_7seg, exp_hex(3, 0, 0));
        end
        #2 rst = 1'b0;
        step(1, 0, 0, 0, 0);
        n_tests++;
        if (alarm !== 1'b0 || hex_7seg !== exp_hex(3, 0, 0)) begin
            n_fail++;
            $display("FAIL residual alarm: alm=%b hex=%h, required alm=0 hex=%h", alarm, hex_7seg, exp_hex(3, 0, 0));
        end
    endtask

    initial begin
        test_reset;
        test_full_countdown;
        test_buttons;
        test_pause_same_cycle;
        test_alarm_blink;
        test_clear;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
